vga_pix_source: RTL and testbench
=================================

Name: vga_pix_source

Overview:
- Source end of the pixel interface: produces Hcounter/Vcounter, HSync/VSync and the 8-bit RGB 3-3-2 PixData that the downstream colour-output stage consumes.
- Reads PixData from an external frame memory (one byte per pixel, 640x480) with one-pixel lookahead.
- PixData is therefore valid in the same cycle that the counters name the pixel.
- Sits between the frame memory and the RGB output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- CLK_DIV, 2, clk cycles per pixel (>=2)
- MEM_LAT, 1, memory read latency in clk cycles (1..CLK_DIV-1)
- ADDR_W, 19, frame memory address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Hcounter  out  10  horizontal position, 0..799
- Vcounter  out  10  vertical position, 0..524
- HSync  out  1  active-low horizontal sync
- VSync  out  1  active-low vertical sync
- VideoOn  out  1  high when Hcounter<H_ACTIVE and Vcounter<V_ACTIVE
- PixData  out  8  RGB 3-3-2 for pixel (Hcounter,Vcounter); 0 when not VideoOn
- MemRdEn  out  1  one-cycle read strobe
- MemAddr  out  ADDR_W  read address, valid with MemRdEn
- MemRdData  in  8  read data, valid MEM_LAT cycles after MemRdEn

Behaviour:
- Reset values (asynchronous): Hcounter=0, Vcounter=0, HSync=1, VSync=1, VideoOn=0, PixData=0, MemRdEn=0, MemAddr=0. Divider=0, prefetch register=0, state=PRIME0.
- Clocking: all sequential logic is on posedge clk.
- Divider: runs 0..CLK_DIV-1 in RUN only. tick=1 when divider==CLK_DIV-1.
- FSM states: PRIME0, PWAIT0, PRIME1, PWAIT1, RUN.
  - PRIME0: MemRdEn=1, MemAddr=0; go to PWAIT0.
  - PWAIT0: wait MEM_LAT cycles; capture MemRdData into PixData; go to PRIME1.
  - PRIME1: MemRdEn=1, MemAddr=1; go to PWAIT1.
  - PWAIT1: wait MEM_LAT cycles; capture MemRdData into the prefetch register; go to RUN.
  - Counters and divider are held during all PRIME/PWAIT states. VideoOn=1 from RUN entry, so pixel (0,0) shows memory byte 0.
- RUN, on each tick (the current position is p):
  - Counters advance to p+1. Hcounter wraps 799->0, and Vcounter increments on that wrap. Vcounter wraps 524->0.
  - PixData <= prefetch register if p+1 is active, else 0.
  - If pixel p+2 is active: MemRdEn=1 for this one cycle, MemAddr=address(p+2).
  - MemRdData is captured into the prefetch register exactly MEM_LAT cycles after MemRdEn.
- Address generation: incremental, no multiplier. A running address increments once per issued read. It is reloaded to 0 when the read for pixel (0,0) is issued (p+2 = (0,0), i.e. p=(798,524)).
- Lookahead across line and frame ends:
  - p+2 is computed with the same wrap rules as the counters.
  - Positions in blanking issue no read.
  - The reads for pixels (0,v+1) and (1,v+1) are issued at p=(798,v) and (799,v).
- Sync decoding:
  - HSync=0 iff 656<=Hcounter<752 (H_ACTIVE+H_FP .. +H_SYNC).
  - VSync=0 iff 490<=Vcounter<492.
  - HSync, VSync and VideoOn are registered and update on the same edge as the counters.
- Reset asserted mid-frame: all outputs return to their reset values immediately, and the block restarts with PRIME0.

Decomposition:
- Shared package holds:
  - the 640x480@60 timing constants (H/V active, porch, sync, totals 800/525);
  - the RGB 3-3-2 colour constants (RED=E0, GREEN=1C, BLUE=03, WHITE=FF, BLACK=00);
  - the FSM state encoding.
- Natural sub-module: vga_timing_core (divider, H/V counters, sync and VideoOn decode, lookahead position). The top level adds the prime FSM, address counter and prefetch/PixData registers.

Test Plan:
- Reset/prime: release rst_n with memory byte[n]=n[7:0] -> MemRdEn pulses at MemAddr 0 then 1. Entering RUN: Hcounter=0, PixData=0x00. Next tick: Hcounter=1, PixData=0x01.
- Line timing: count ticks -> Hcounter wraps after 800. HSync low for exactly 96 ticks starting at Hcounter=656. PixData=0 for Hcounter 640..799.
- Frame timing: run a full frame -> VSync low for Vcounter 490..491 only. Vcounter wraps 524->0. Exactly 307200 MemRdEn pulses per steady-state frame.
- Address continuity: at (0,1), MemAddr for that pixel=640 and PixData=byte[640]. At (639,479), PixData=byte[307199]. The read at p=(798,524) has MemAddr=0.
- Latency sweep: CLK_DIV=4 with MEM_LAT=3 -> PixData at every active position equals byte[v*640+h]. No MemRdEn outside lookahead-active positions.
- Mid-frame reset: assert rst_n=0 at (300,200) -> all outputs return to reset values asynchronously. After release, the prime sequence repeats and the first RUN pixel is byte[0].

Source files
------------

// File: rtl/vga_pix_source_pkg.sv
// Shared definitions for the VGA pixel source: 640x480@60 timing, RGB 3-3-2 colours,
// prime FSM encoding and raster-position helpers.
package vga_pix_source_pkg;

  localparam int unsigned VgaHActive = 640;
  localparam int unsigned VgaHFp     = 16;
  localparam int unsigned VgaHSync   = 96;
  localparam int unsigned VgaHBp     = 48;
  localparam int unsigned VgaHTotal  = VgaHActive + VgaHFp + VgaHSync + VgaHBp;
  localparam int unsigned VgaVActive = 480;
  localparam int unsigned VgaVFp     = 10;
  localparam int unsigned VgaVSync   = 2;
  localparam int unsigned VgaVBp     = 33;
  localparam int unsigned VgaVTotal  = VgaVActive + VgaVFp + VgaVSync + VgaVBp;

  localparam logic [7:0] ColRed   = 8'hE0;
  localparam logic [7:0] ColGreen = 8'h1C;
  localparam logic [7:0] ColBlue  = 8'h03;
  localparam logic [7:0] ColWhite = 8'hFF;
  localparam logic [7:0] ColBlack = 8'h00;

  localparam int unsigned CntW = 10;
  typedef logic [CntW-1:0] cnt_t;

  typedef struct packed {
    cnt_t h;
    cnt_t v;
  } pos_t;

  typedef enum logic [2:0] {StPrime0, StPwait0, StPrime1, StPwait1, StRun} state_e;

  // Raster-order successor of a position, wrapping at line and frame ends.
  function automatic pos_t pos_inc(pos_t p, int unsigned h_tot, int unsigned v_tot);
    pos_t n;
    n = p;
    if (p.h == cnt_t'(h_tot - 1)) begin
      n.h = '0;
      n.v = (p.v == cnt_t'(v_tot - 1)) ? '0 : p.v + cnt_t'(1);
    end else begin
      n.h = p.h + cnt_t'(1);
    end
    return n;
  endfunction

  function automatic logic pos_active(pos_t p, int unsigned h_act, int unsigned v_act);
    return (p.h < cnt_t'(h_act)) && (p.v < cnt_t'(v_act));
  endfunction

endpackage

// File: rtl/vga_pix_source_timing_core.sv
// Pixel divider, H/V raster counters, registered sync/VideoOn decode and the
// one- and two-pixel lookahead flags used by the memory prefetch.
module vga_pix_source_timing_core
  import vga_pix_source_pkg::*;
#(
  parameter int unsigned HActive = VgaHActive,
  parameter int unsigned HFp     = VgaHFp,
  parameter int unsigned HSync   = VgaHSync,
  parameter int unsigned HBp     = VgaHBp,
  parameter int unsigned VActive = VgaVActive,
  parameter int unsigned VFp     = VgaVFp,
  parameter int unsigned VSync   = VgaVSync,
  parameter int unsigned VBp     = VgaVBp,
  parameter int unsigned ClkDiv  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            start_i,
  output logic            tick_o,
  output logic [CntW-1:0] h_o,
  output logic [CntW-1:0] v_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            video_on_o,
  output logic            nxt_active_o,
  output logic            la_active_o,
  output logic            la_origin_o
);

  localparam int unsigned HTot = HActive + HFp + HSync + HBp;
  localparam int unsigned VTot = VActive + VFp + VSync + VBp;
  localparam int unsigned DivW = $clog2(ClkDiv);

  logic [DivW-1:0] div_q, div_d;
  pos_t            pos_q, pos_d, pos1, pos2;
  logic            hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;

  always_comb begin
    pos1         = pos_inc(pos_q, HTot, VTot);
    pos2         = pos_inc(pos1, HTot, VTot);
    tick_o       = en_i && (div_q == DivW'(ClkDiv - 1));
    nxt_active_o = pos_active(pos1, HActive, VActive);
    la_active_o  = pos_active(pos2, HActive, VActive);
    la_origin_o  = (pos2 == '0);

    div_d      = div_q;
    pos_d      = pos_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    if (en_i) begin
      div_d = tick_o ? '0 : div_q + DivW'(1);
    end
    // Sync and VideoOn describe the position the counters move to on this edge.
    if (tick_o) begin
      pos_d      = pos1;
      hsync_d    = !((pos1.h >= cnt_t'(HActive + HFp)) && (pos1.h < cnt_t'(HActive + HFp + HSync)));
      vsync_d    = !((pos1.v >= cnt_t'(VActive + VFp)) && (pos1.v < cnt_t'(VActive + VFp + VSync)));
      video_on_d = nxt_active_o;
    end else if (start_i) begin
      video_on_d = pos_active(pos_q, HActive, VActive);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= '0;
      pos_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pos_q      <= pos_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign h_o        = pos_q.h;
  assign v_o        = pos_q.v;
  assign hsync_o    = hsync_q;
  assign vsync_o    = vsync_q;
  assign video_on_o = video_on_q;

endmodule

// File: rtl/vga_pix_source.sv
// VGA pixel source: raster timing plus a frame-memory reader that primes two pixels and
// then prefetches one pixel ahead so PixData lines up with the counters.
module vga_pix_source
  import vga_pix_source_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VgaHActive,
  parameter int unsigned H_FP     = VgaHFp,
  parameter int unsigned H_SYNC   = VgaHSync,
  parameter int unsigned H_BP     = VgaHBp,
  parameter int unsigned V_ACTIVE = VgaVActive,
  parameter int unsigned V_FP     = VgaVFp,
  parameter int unsigned V_SYNC   = VgaVSync,
  parameter int unsigned V_BP     = VgaVBp,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [CntW-1:0]   Hcounter,
  output logic [CntW-1:0]   Vcounter,
  output logic              HSync,
  output logic              VSync,
  output logic              VideoOn,
  output logic [7:0]        PixData,
  output logic              MemRdEn,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [7:0]        MemRdData
);

  state_e             state_q;
  logic               rd_en_q;
  logic [ADDR_W-1:0]  rd_addr_q, addr_cnt_q, la_addr;
  logic [7:0]         pix_q, pref_q;
  logic [MEM_LAT-1:0] pend_q;
  logic               cap, start, tick, nxt_active, la_active, la_origin;

  // pend_q tracks outstanding reads; the top bit marks the cycle their data is valid.
  assign cap     = pend_q[MEM_LAT-1];
  assign start   = (state_q == StPwait1) && cap;
  assign la_addr = la_origin ? '0 : addr_cnt_q;

  vga_pix_source_timing_core #(
    .HActive(H_ACTIVE),
    .HFp    (H_FP),
    .HSync  (H_SYNC),
    .HBp    (H_BP),
    .VActive(V_ACTIVE),
    .VFp    (V_FP),
    .VSync  (V_SYNC),
    .VBp    (V_BP),
    .ClkDiv (CLK_DIV)
  ) u_timing (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (state_q == StRun),
    .start_i     (start),
    .tick_o      (tick),
    .h_o         (Hcounter),
    .v_o         (Vcounter),
    .hsync_o     (HSync),
    .vsync_o     (VSync),
    .video_on_o  (VideoOn),
    .nxt_active_o(nxt_active),
    .la_active_o (la_active),
    .la_origin_o (la_origin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StPrime0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      addr_cnt_q <= '0;
      pix_q      <= '0;
      pref_q     <= '0;
      pend_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      pend_q  <= (pend_q << 1) | MEM_LAT'(rd_en_q);
      unique case (state_q)
        StPrime0: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
          state_q   <= StPwait0;
        end
        StPwait0: begin
          if (cap) begin
            pix_q   <= MemRdData;
            state_q <= StPrime1;
          end
        end
        StPrime1: begin
          rd_en_q   <= 1'b1;
          rd_addr_q <= ADDR_W'(1);
          state_q   <= StPwait1;
        end
        StPwait1: begin
          if (cap) begin
            pref_q     <= MemRdData;
            addr_cnt_q <= ADDR_W'(2);
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (cap) pref_q <= MemRdData;
          if (tick) begin
            // With MEM_LAT == CLK_DIV-1 the data lands on the tick edge itself.
            pix_q <= nxt_active ? (cap ? MemRdData : pref_q) : ColBlack;
            if (la_active) begin
              rd_en_q    <= 1'b1;
              rd_addr_q  <= la_addr;
              addr_cnt_q <= la_addr + ADDR_W'(1);
            end
          end
        end
        default: state_q <= StPrime0;
      endcase
    end
  end

  assign MemRdEn = rd_en_q;
  assign MemAddr = rd_addr_q;
  assign PixData = pix_q;

endmodule

// File: tb/tb_vga_pix_source.sv
// Directed bench: a full-size instance for prime/line timing and a shrunken-raster instance
// (CLK_DIV=4, MEM_LAT=3) for frame timing, address wrap and mid-frame reset.
module tb_vga_pix_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, b_rst_n;
  logic [9:0]  a_h, a_v, b_h, b_v;
  logic        a_hs, a_vs, a_von, a_en, b_hs, b_vs, b_von, b_en;
  logic [7:0]  a_pix, b_pix;
  logic [7:0]  a_rd = 8'h5A;
  logic [7:0]  b_rd = 8'h5A, b_s0 = 8'h5A, b_s1 = 8'h5A;
  logic [18:0] a_addr, b_addr;

  int checks = 0;
  int errors = 0;

  vga_pix_source u_a (
    .clk(clk), .rst_n(a_rst_n), .Hcounter(a_h), .Vcounter(a_v), .HSync(a_hs), .VSync(a_vs),
    .VideoOn(a_von), .PixData(a_pix), .MemRdEn(a_en), .MemAddr(a_addr), .MemRdData(a_rd)
  );

  vga_pix_source #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(4), .MEM_LAT(3), .ADDR_W(19)
  ) u_b (
    .clk(clk), .rst_n(b_rst_n), .Hcounter(b_h), .Vcounter(b_v), .HSync(b_hs), .VSync(b_vs),
    .VideoOn(b_von), .PixData(b_pix), .MemRdEn(b_en), .MemAddr(b_addr), .MemRdData(b_rd)
  );

  // Frame memories: byte[n] = n[7:0]; junk on the bus when no read is in flight.
  always @(posedge clk) a_rd <= a_en ? a_addr[7:0] : 8'h5A;
  always @(posedge clk) begin
    b_s0 <= b_en ? b_addr[7:0] : 8'h5A;
    b_s1 <= b_s0;
    b_rd <= b_s1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int n_rd, rd0, rd1, exp_h, exp_v, exp_addr, addr_bad, pix_bad, von_bad, order_bad, hs_cnt;
  int hs_first, hs_bad, vs_bad, vs_cnt, addr_last, pix_end, wraps, frame_rd, noact_rd, dh, dv;
  int lh, lv;
  bit done, first, act;
  logic [7:0] exp_pix;

  initial begin
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("a_rst_h", a_h, 0);
    check("a_rst_v", a_v, 0);
    check("a_rst_hs", a_hs, 1);
    check("a_rst_vs", a_vs, 1);
    check("a_rst_von", a_von, 0);
    check("a_rst_pix", a_pix, 0);
    check("a_rst_en", a_en, 0);
    check("a_rst_addr", a_addr, 0);

    // Prime on the full-size instance
    a_rst_n = 1'b1;
    n_rd = 0; rd0 = -1; rd1 = -1;
    for (int i = 0; i < 30 && !a_von; i++) begin
      @(negedge clk);
      if (a_en) begin
        if (n_rd == 0) rd0 = a_addr; else if (n_rd == 1) rd1 = a_addr;
        n_rd++;
      end
    end
    check("a_prime_von", a_von, 1);
    check("a_prime_reads", n_rd, 2);
    check("a_prime_addr0", rd0, 0);
    check("a_prime_addr1", rd1, 1);
    check("a_run_h", a_h, 0);
    check("a_run_v", a_v, 0);
    check("a_run_pix", a_pix, 8'h00);
    for (int i = 0; i < 10 && a_h == 0; i++) @(negedge clk);
    check("a_tick1_h", a_h, 1);
    check("a_tick1_pix", a_pix, 8'h01);

    // Line 0 scan, ending at the first sample of (0,1)
    exp_h = 1; exp_addr = 2; n_rd = 0; addr_bad = 0; pix_bad = 0; von_bad = 0; order_bad = 0;
    hs_cnt = 0; hs_first = -1; vs_bad = 0; addr_last = -1; pix_end = -1; done = 0; first = 1;
    dh = 0;
    for (int i = 0; i < 2000; i++) begin
      if (first || a_h != 10'(dh)) begin
        first = 0;
        dh = a_h;
        if (exp_h == 800) begin
          done = 1;
          pix_end = a_pix;
          check("a_wrap_h", a_h, 0);
          check("a_wrap_v", a_v, 1);
        end else begin
          if (a_h !== 10'(exp_h) || a_v !== 10'd0) order_bad++;
          if (!a_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = exp_h;
          end
          if (!a_vs) vs_bad++;
          exp_pix = (exp_h < 640) ? 8'(exp_h) : 8'h00;
          if (a_pix !== exp_pix) pix_bad++;
          if (a_von !== (exp_h < 640)) von_bad++;
          exp_h++;
        end
      end
      if (a_en) begin
        n_rd++;
        if (a_addr !== 19'(exp_addr)) addr_bad++;
        if (a_h == 10'd799) addr_last = a_addr;
        exp_addr++;
      end
      if (done) break;
      @(negedge clk);
    end
    check("a_line_done", done, 1);
    check("a_line_order", order_bad, 0);
    check("a_line_reads", n_rd, 640);
    check("a_line_addr", addr_bad, 0);
    check("a_addr_0_1", addr_last, 640);
    check("a_hsync_len", hs_cnt, 96);
    check("a_hsync_start", hs_first, 656);
    check("a_vsync_line0", vs_bad, 0);
    check("a_line_pix", pix_bad, 0);
    check("a_line_von", von_bad, 0);
    check("a_pix_0_1", pix_end, 8'h80);

    // Small-raster instance: reset values, prime, two full frames
    check("b_rst_h", b_h, 0);
    check("b_rst_hs", b_hs, 1);
    check("b_rst_vs", b_vs, 1);
    check("b_rst_en", b_en, 0);
    b_rst_n = 1'b1;
    n_rd = 0; rd0 = -1; rd1 = -1;
    for (int i = 0; i < 60 && !b_von; i++) begin
      @(negedge clk);
      if (b_en) begin
        if (n_rd == 0) rd0 = b_addr; else if (n_rd == 1) rd1 = b_addr;
        n_rd++;
      end
    end
    check("b_prime_von", b_von, 1);
    check("b_prime_reads", n_rd, 2);
    check("b_prime_addr0", rd0, 0);
    check("b_prime_addr1", rd1, 1);
    check("b_run_pix", b_pix, 8'h00);

    exp_h = 0; exp_v = 0; exp_addr = 2; addr_bad = 0; pix_bad = 0; von_bad = 0; order_bad = 0;
    hs_bad = 0; vs_bad = 0; vs_cnt = 0; wraps = 0; frame_rd = 0; noact_rd = 0; addr_last = -1;
    pix_end = -1; first = 1; dh = 0; dv = 0;
    for (int i = 0; i < 2000 && wraps < 2; i++) begin
      if (first || b_h != 10'(dh) || b_v != 10'(dv)) begin
        if (!first && exp_h == 0 && exp_v == 0) wraps++;
        first = 0;
        dh = exp_h; dv = exp_v;
        if (b_h !== 10'(exp_h) || b_v !== 10'(exp_v)) order_bad++;
        act = (exp_h < 8) && (exp_v < 4);
        if (b_von !== act) von_bad++;
        exp_pix = act ? 8'(exp_v * 8 + exp_h) : 8'h00;
        if (b_pix !== exp_pix) pix_bad++;
        if (b_hs !== !(exp_h >= 10 && exp_h < 13)) hs_bad++;
        if (!b_vs) begin
          vs_cnt++;
          if (exp_v < 5 || exp_v > 6) vs_bad++;
        end
        if (exp_h == 7 && exp_v == 3) pix_end = b_pix;
        exp_h++;
        if (exp_h == 15) begin
          exp_h = 0;
          exp_v = (exp_v == 7) ? 0 : exp_v + 1;
        end
      end
      if (b_en && wraps < 2) begin
        if (b_addr !== 19'(exp_addr)) addr_bad++;
        exp_addr = (exp_addr == 31) ? 0 : exp_addr + 1;
        lh = (dh == 14) ? 0 : dh + 1;
        lv = (dh == 14) ? ((dv == 7) ? 0 : dv + 1) : dv;
        if (!(lh < 8 && lv < 4)) noact_rd++;
        if (wraps == 1) frame_rd++;
        if (dh == 14 && dv == 7) addr_last = b_addr;
      end
      if (wraps < 2) @(negedge clk);
    end
    check("b_frames_seen", wraps, 2);
    check("b_order", order_bad, 0);
    check("b_von", von_bad, 0);
    check("b_pix", pix_bad, 0);
    check("b_pix_last", pix_end, 31);
    check("b_hsync", hs_bad, 0);
    check("b_vsync_rows", vs_bad, 0);
    check("b_vsync_cnt", vs_cnt, 60);
    check("b_addr_seq", addr_bad, 0);
    check("b_rd_blank", noact_rd, 0);
    check("b_frame_reads", frame_rd, 32);
    check("b_addr_origin", addr_last, 0);

    // Mid-frame asynchronous reset at (5,2)
    for (int i = 0; i < 600 && !(b_h == 10'd5 && b_v == 10'd2); i++) @(negedge clk);
    check("b_mid_reach_h", b_h, 5);
    check("b_mid_reach_v", b_v, 2);
    #2 b_rst_n = 1'b0;
    #1;
    check("b_mid_h", b_h, 0);
    check("b_mid_v", b_v, 0);
    check("b_mid_hs", b_hs, 1);
    check("b_mid_vs", b_vs, 1);
    check("b_mid_von", b_von, 0);
    check("b_mid_pix", b_pix, 0);
    check("b_mid_en", b_en, 0);
    check("b_mid_addr", b_addr, 0);
    repeat (2) @(negedge clk);
    b_rst_n = 1'b1;
    n_rd = 0; rd0 = -1; rd1 = -1;
    for (int i = 0; i < 60 && !b_von; i++) begin
      @(negedge clk);
      if (b_en) begin
        if (n_rd == 0) rd0 = b_addr; else if (n_rd == 1) rd1 = b_addr;
        n_rd++;
      end
    end
    check("b_reprime_von", b_von, 1);
    check("b_reprime_addr0", rd0, 0);
    check("b_reprime_addr1", rd1, 1);
    check("b_reprime_pix", b_pix, 8'h00);
    for (int i = 0; i < 20 && b_h == 0; i++) @(negedge clk);
    check("b_reprime_h1", b_h, 1);
    check("b_reprime_pix1", b_pix, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
